alu_pipe: RTL and testbench

Parametrised multi-bit successor to the 1-bit arithmetic/logic slice (mode select M, function select S1:S0, carry in/out).
- Same function set, generalised to WIDTH bits.
- Adds status flags, a registered result with valid/ready handshake, and an optional accumulator that can replace operand A.
- Sits between the datapath operand source and any consumer that may stall.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 54 +++++
 rtl/alu_pipe.sv | 105 ++++++++++
 tb/tb_alu_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and flag type for the pipelined ALU
package alu_pkg;

  // Mode select (m)
  localparam logic ALU_ARITH = 1'b0;
  localparam logic ALU_LOGIC = 1'b1;

  // Arithmetic function select (s) when m = ALU_ARITH
  localparam logic [1:0] FN_PASS = 2'b00;
  localparam logic [1:0] FN_ADD  = 2'b01;
  localparam logic [1:0] FN_SUB  = 2'b10;
  localparam logic [1:0] FN_DEC  = 2'b11;

  // Logic function select (s) when m = ALU_LOGIC
  localparam logic [1:0] FN_AND  = 2'b00;
  localparam logic [1:0] FN_OR   = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_NOT  = 2'b11;

  // Status flags registered alongside the result
  typedef struct packed {
    logic co;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational WIDTH-bit arithmetic/logic slice with flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [1:0]       s,
  input  logic             m,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   sum;

  // Select the second adder operand, add with carry, or apply the bitwise function
  always_comb begin
    p   = '0;
    sum = '0;
    f   = '0;
    co  = 1'b0;
    ovf = 1'b0;
    if (m == ALU_ARITH) begin
      case (s)
        FN_PASS: p = '0;
        FN_ADD:  p = b;
        FN_SUB:  p = ~b;
        default: p = '1;
      endcase
      sum = {1'b0, a} + {1'b0, p} + {{WIDTH{1'b0}}, ci};
      f   = sum[WIDTH-1:0];
      co  = sum[WIDTH];
      // Signed overflow: both addends share a sign that the result does not
      ovf = (a[WIDTH-1] == p[WIDTH-1]) & (f[WIDTH-1] != a[WIDTH-1]);
    end else begin
      case (s)
        FN_AND:  f = a & b;
        FN_OR:   f = a | b;
        FN_XOR:  f = a ^ b;
        default: f = ~a;
      endcase
    end
  end

  assign zero = (f == '0);
  assign neg  = f[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and accumulator
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [1:0]       s,
  input  logic             m,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic [WIDTH-1:0] acc_q
);

  logic             in_fire;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_f;
  alu_flags_t       core_flags;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] f_q, f_d;
  alu_flags_t       flags_q, flags_d;
  logic [WIDTH-1:0] acc_d;

  // Single output register: a new op is taken whenever the slot is empty or being drained
  assign in_ready = !out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign a_eff    = ((ACC_EN != 0) && acc_sel) ? acc_q : a;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (a_eff),
    .b    (b),
    .ci   (ci),
    .s    (s),
    .m    (m),
    .f    (core_f),
    .co   (core_flags.co),
    .zero (core_flags.zero),
    .neg  (core_flags.neg),
    .ovf  (core_flags.ovf)
  );

  // Next-state for the output slot and the accumulator
  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      f_d         = core_f;
      flags_d     = core_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (ACC_EN != 0) begin
      if (in_fire) begin
        acc_d = core_f;
      end
      // Clear takes priority over a same-cycle result; f still shows that result
      if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  // State registers; reset drops any held result immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign co        = flags_q.co;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ci = 1'b0;
  logic [1:0] s = '0;
  logic       m = 1'b0;
  logic       acc_sel = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] f;
  logic       co, zero, neg, ovf;
  logic [7:0] acc_q;

  typedef struct {
    logic [7:0] f;
    logic       co;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic [7:0] acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_acc = '0;
  int         n_checks = 0;
  int         n_fail = 0;

  alu_pipe #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .s         (s),
    .m         (m),
    .acc_sel   (acc_sel),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .co        (co),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .acc_q     (acc_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer add with signed range test for overflow
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ici, input logic [1:0] is_, input logic im);
    exp_t e;
    logic [7:0] p;
    int us, ss;
    e.co = 1'b0;
    e.ovf = 1'b0;
    if (im) begin
      case (is_)
        2'd0: e.f = ia & ib;
        2'd1: e.f = ia | ib;
        2'd2: e.f = ia ^ ib;
        default: e.f = ~ia;
      endcase
    end else begin
      case (is_)
        2'd0: p = 8'h00;
        2'd1: p = ib;
        2'd2: p = ~ib;
        default: p = 8'hFF;
      endcase
      us = int'(ia) + int'(p) + int'(ici);
      ss = int'($signed(ia)) + int'($signed(p)) + int'(ici);
      e.f = us[7:0];
      e.co = (us > 255);
      e.ovf = (ss > 127) || (ss < -128);
    end
    e.zero = (e.f == 8'h00);
    e.neg = e.f[7];
    e.acc = 8'h00;
    return e;
  endfunction

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                      input logic [1:0] is_, input logic im, input logic isel, input logic iclr,
                      input logic use_exp, input logic [7:0] ef, input logic [3:0] efl,
                      input logic [7:0] eacc);
    exp_t e;
    int waited;
    a = ia; b = ib; ci = ici; s = is_; m = im; acc_sel = isel; acc_clr = iclr;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    e = model(isel ? model_acc : ia, ib, ici, is_, im);
    model_acc = iclr ? 8'h00 : e.f;
    e.acc = model_acc;
    if (use_exp) begin
      e.f = ef;
      {e.co, e.zero, e.neg, e.ovf} = efl;
      e.acc = eacc;
      model_acc = eacc;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output side: compare each result on the cycle it is handed over
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("f", f, e.f);
          check("co", co, e.co);
          check("zero", zero, e.zero);
          check("neg", neg, e.neg);
          check("ovf", ovf, e.ovf);
          check("acc", acc_q, e.acc);
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_flags", {co, zero, neg, ovf}, 0);
    check("rst_acc", acc_q, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Arithmetic directed vectors (flags are {co,zero,neg,ovf})
    send(8'h7F, 8'h01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 4'b0011, 8'h80);
    send(8'h05, 8'h05, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b1100, 8'h00);
    send(8'h00, 8'h01, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'b0010, 8'hFF);
    send(8'h80, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 4'b1001, 8'h7F);
    send(8'hFF, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'b1100, 8'h00);
    // Logic functions
    send(8'hF0, 8'h3C, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 4'b0000, 8'h30);
    send(8'hF0, 8'h3C, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFC, 4'b0010, 8'hFC);
    send(8'hF0, 8'h3C, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCC, 4'b0010, 8'hCC);
    send(8'hF0, 8'h3C, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 4'b0000, 8'h0F);
    drain();

    // Accumulate
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_acc = 8'h00;
    check("acc_clr_pulse", acc_q, 0);
    send(8'hAA, 8'h10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 4'b0000, 8'h10);
    send(8'hAA, 8'h10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 4'b0000, 8'h20);
    send(8'hAA, 8'h10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 4'b0000, 8'h30);
    send(8'hAA, 8'h10, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 4'b0000, 8'h00);
    drain();

    // Backpressure: hold 0x7F+1 for three cycles, then release with a new op
    out_ready = 1'b0;
    send(8'h7F, 8'h01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 4'b0011, 8'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_f", f, 8'h80);
      check("hold_flags", {co, zero, neg, ovf}, 4'b0011);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h12, 8'h34, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46, 4'b0000, 8'h46);
    @(negedge clk);
    check("no_gap_valid", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    send(8'h5A, 8'hFF, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'b0010, 8'hA5);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_f", f, 0);
    check("arst_flags", {co, zero, neg, ovf}, 0);
    check("arst_acc", acc_q, 0);
    sb.delete();
    model_acc = 8'h00;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Random traffic with random stalls and accumulator use
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b0, 8'h00, 4'h0, 8'h00);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
